// File: rtl/priority_codec_pkg.sv
// ----------------------------------------------------------------------------
// Module   : priority_codec_pkg
// Brief    : Shared widths, entry layout and decode helper for the codec.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package priority_codec_pkg;

   localparam int CODE_W        = 3;
   localparam int ONEHOT_W      = 8;
   localparam int DEPTH_DEFAULT = 4;
   localparam int ENTRY_W       = CODE_W + 1;

   // Encoder side reports "no input active" with this flag instead of a code.
   localparam logic NONE_ACTIVE = 1'b1;

   typedef struct packed {
      logic              none;
      logic [CODE_W-1:0] code;
   } code_entry_t;

   function automatic logic [ONEHOT_W-1:0] decode_entry(code_entry_t e);
      logic [ONEHOT_W-1:0] oh;
      oh = '0;
      if (e.none != NONE_ACTIVE) begin
         for (int i = 0; i < ONEHOT_W; i++) begin
            if (e.code == CODE_W'(i)) begin
               oh[i] = 1'b1;
            end
         end
      end
      return oh;
   endfunction

endpackage

`default_nettype wire

// File: rtl/code_fifo.sv
// ----------------------------------------------------------------------------
// Module   : code_fifo
// Brief    : Power-of-two circular buffer holding {none, code} entries.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module code_fifo
   import priority_codec_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
         end
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/priority_decoder.sv
// ----------------------------------------------------------------------------
// Module   : priority_decoder
// Brief    : Buffered 3-to-8 one-hot decoder with output register and seen mask.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module priority_decoder
   import priority_codec_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CODE_W-1:0]        in_code,
   input  logic                     in_none,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ONEHOT_W-1:0]      out_onehot,
   output logic [ONEHOT_W-1:0]      seen_mask,
   input  logic                     clr_seen,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic                w_handshake;
   logic [ENTRY_W-1:0]  w_head;
   logic [CNT_W-1:0]    w_count;

   logic                out_valid_q,  out_valid_d;
   logic [ONEHOT_W-1:0] out_onehot_q, out_onehot_d;
   logic [ONEHOT_W-1:0] seen_q,       seen_d;

   code_entry_t w_wentry;

   assign w_wentry    = '{none: in_none, code: in_code};
   assign in_ready    = (w_count != CNT_FULL);
   assign w_push      = in_valid && in_ready;
   assign w_handshake = out_valid_q && out_ready;
   assign w_pop       = !w_empty && (!out_valid_q || out_ready);

   code_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .wdata_i (w_wentry),
      .rdata_o (w_head),
      .count_o (w_count),
      .empty_o (w_empty)
   );

   always_comb begin
      out_valid_d  = out_valid_q;
      out_onehot_d = out_onehot_q;
      seen_d       = seen_q;
      if (w_pop) begin
         out_valid_d  = 1'b1;
         out_onehot_d = decode_entry(code_entry_t'(w_head));
      end else if (w_handshake) begin
         out_valid_d  = 1'b0;
         out_onehot_d = '0;
      end
      // A clear coinciding with a handshake keeps only the value just delivered.
      if (clr_seen) begin
         seen_d = w_handshake ? out_onehot_q : '0;
      end else if (w_handshake) begin
         seen_d = seen_q | out_onehot_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_onehot_q <= '0;
         seen_q       <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_onehot_q <= out_onehot_d;
         seen_q       <= seen_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_onehot = out_onehot_q;
   assign seen_mask  = seen_q;
   assign count      = w_count;

endmodule

`default_nettype wire

// File: tb/tb_priority_decoder.sv
// ----------------------------------------------------------------------------
// Module   : tb_priority_decoder
// Brief    : Directed and random stimulus against a queue-based reference model.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_priority_decoder;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_code;
   logic       in_none;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_onehot;
   logic [7:0] seen_mask;
   logic       clr_seen;
   logic [2:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: pending entries, plus the value currently on the output.
   logic [3:0] m_fifo[$];
   logic       m_ov;
   logic [7:0] m_val;
   logic [7:0] m_seen;

   priority_decoder #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .in_none    (in_none),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .seen_mask  (seen_mask),
      .clr_seen   (clr_seen),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_decode(input logic [3:0] e);
      logic [7:0] one;
      one = 8'd1;
      return e[3] ? 8'h00 : (one << e[2:0]);
   endfunction

   task automatic model_clear();
      m_fifo.delete();
      m_ov   = 1'b0;
      m_val  = 8'h00;
      m_seen = 8'h00;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".x"},     32'($isunknown({in_ready, out_valid, out_onehot, seen_mask, count})), 32'd0);
      check_val({tag, ".ov"},    32'(out_valid),  32'(m_ov));
      check_val({tag, ".oh"},    32'(out_onehot), 32'(m_val));
      check_val({tag, ".seen"},  32'(seen_mask),  32'(m_seen));
      check_val({tag, ".count"}, 32'(count),      32'(m_fifo.size()));
   endtask

   // Called just after a falling edge; returns just after the next one.
   task automatic drive_cycle(input logic v, input logic [2:0] c, input logic n,
                              input logic ordy, input logic clr, input string tag);
      logic ready_m, hs, acc, load;
      in_valid  = v;
      in_code   = c;
      in_none   = n;
      out_ready = ordy;
      clr_seen  = clr;
      #1;
      ready_m = (m_fifo.size() != DEPTH);
      check_val({tag, ".in_ready"}, 32'(in_ready), 32'(ready_m));
      @(posedge clk);
      hs   = m_ov && ordy;
      acc  = v && ready_m;
      load = (m_fifo.size() != 0) && (!m_ov || ordy);
      if (clr)     m_seen = hs ? m_val : 8'h00;
      else if (hs) m_seen = m_seen | m_val;
      if (load) begin
         m_val = m_decode(m_fifo.pop_front());
         m_ov  = 1'b1;
      end else if (hs) begin
         m_ov  = 1'b0;
         m_val = 8'h00;
      end
      if (acc) m_fifo.push_back({n, c});
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic idle(input int cycles, input logic ordy, input string tag);
      for (int i = 0; i < cycles; i++) drive_cycle(1'b0, 3'd0, 1'b0, ordy, 1'b0, tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_code   = 3'd0;
      in_none   = 1'b0;
      out_ready = 1'b0;
      clr_seen  = 1'b0;
      model_clear();
      #1;
      check_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("reset.in_ready", 32'(in_ready), 32'd1);

      // Single item: latency of two edges from acceptance.
      drive_cycle(1'b1, 3'd5, 1'b0, 1'b1, 1'b0, "single.acc");
      check_val("single.not_yet", 32'(out_valid), 32'd0);
      drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "single.out");
      check_val("single.oh20", 32'(out_onehot), 32'h20);
      drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "single.hs");
      check_val("single.seen20", 32'(seen_mask), 32'h20);

      // Backpressure fill, then drain in order.
      for (int c = 0; c < 5; c++) drive_cycle(1'b1, 3'(c), 1'b0, 1'b0, 1'b0, "fill");
      check_val("fill.oh01", 32'(out_onehot), 32'h01);
      check_val("fill.count4", 32'(count), 32'd4);
      drive_cycle(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, "fill.blocked");
      check_val("fill.in_ready0", 32'(in_ready), 32'd0);
      drive_cycle(1'b1, 3'd7, 1'b0, 1'b1, 1'b0, "fill.pop_full");
      idle(6, 1'b1, "drain");

      // Streaming through pointer wrap.
      drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, "stream.clr");
      for (int r = 0; r < 3; r++)
         for (int c = 7; c >= 0; c--) drive_cycle(1'b1, 3'(c), 1'b0, 1'b1, 1'b0, "stream");
      idle(3, 1'b1, "stream.tail");
      check_val("stream.seenFF", 32'(seen_mask), 32'hFF);

      // None entry and clear-with-handshake.
      drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, "none.clr");
      drive_cycle(1'b1, 3'd6, 1'b0, 1'b1, 1'b0, "none.c6");
      idle(2, 1'b1, "none.c6d");
      drive_cycle(1'b1, 3'd3, 1'b1, 1'b1, 1'b0, "none.acc");
      drive_cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "none.out");
      check_val("none.oh00", 32'(out_onehot), 32'h00);
      check_val("none.ov1", 32'(out_valid), 32'd1);
      drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "none.hs");
      check_val("none.seen40", 32'(seen_mask), 32'h40);
      drive_cycle(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, "clr.acc");
      drive_cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "clr.load");
      drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, "clr.hs");
      check_val("clr.seen04", 32'(seen_mask), 32'h04);

      // Reset mid-operation with three queued entries and a held output.
      for (int c = 1; c < 5; c++) drive_cycle(1'b1, 3'(c), 1'b0, 1'b0, 1'b0, "mid.fill");
      check_val("mid.count3", 32'(count), 32'd3);
      check_val("mid.ov1", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_outputs("mid.rst");
      @(negedge clk);
      rst_n = 1'b1;
      idle(4, 1'b1, "mid.after");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive_cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 31) == 0, "rand");
      end
      idle(6, 1'b1, "rand.drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: input code is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a code.
REQ-006 SHALL have port in_code, input, 3 bits: encoded index 0..7; bit 7 has the highest priority.
REQ-007 SHALL have port in_none, input, 1 bit: no input was active; decodes to all-zero.
REQ-008 SHALL have port out_valid, output, 1 bit: out_onehot is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts out_onehot.
REQ-010 SHALL have port out_onehot, output, 8 bits: decoded one-hot value, or zero.
REQ-011 SHALL have port seen_mask, output, 8 bits: OR of all one-hots delivered since the last clear.
REQ-012 SHALL have port clr_seen, input, 1 bit: synchronous clear of seen_mask.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1 bits: FIFO occupancy, excluding the output register.

Function
REQ-014 SHALL accept an input on a rising edge only when in_valid and in_ready are both 1; it stores {in_none, in_code} in the FIFO.
REQ-015 SHALL drive in_ready = (count != DEPTH); in_ready is combinational from state only, never from out_ready.
REQ-016 SHALL decode each entry as follows: in_none=1 gives 8'h00; otherwise bit in_code of out_onehot is set and all other bits are 0.
REQ-017 SHALL load the output register from the FIFO head when out_valid=0, or when out_valid=1 and out_ready=1, and the FIFO is non-empty.
REQ-018 SHALL give a code accepted at edge t into an empty block out_valid=1 with the decoded value after edge t+1 (latency 2 edges, no bypass).
REQ-019 SHALL hold out_onehot and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, after an output handshake with the FIFO empty, clear out_valid to 0 and out_onehot to 8'h00 at the next edge.
REQ-021 SHALL sustain one item per cycle with out_ready held at 1 and in_valid held at 1.
REQ-022 SHALL decrement count when an entry moves to the output register; simultaneous push and pop SHALL leave count unchanged.
REQ-023 SHALL let read and write pointers wrap modulo DEPTH with no gap or duplicate at the wrap.
REQ-024 SHALL NOT push a new entry when full (in_ready=0), even when a pop occurs in the same cycle; in_ready rises the cycle after count drops.
REQ-025 SHALL update seen_mask to seen_mask | out_onehot on each output handshake.
REQ-026 SHALL clear seen_mask to 0 when clr_seen=1.
REQ-027 SHALL set seen_mask to exactly the handshaked one-hot when clr_seen and an output handshake occur in the same cycle.
REQ-028 SHALL ignore in_code whenever in_none=1 and SHALL never produce X on any output.

Reset
REQ-029 SHALL, while rst_n=0, immediately force out_valid=0, out_onehot=8'h00, seen_mask=8'h00, count=0, and both pointers to 0.
REQ-030 SHALL discard all FIFO contents and any in-flight output on reset asserted mid-operation; no partial item appears after release.
REQ-031 SHALL drive in_ready=1 the first cycle after reset release when DEPTH>=1.

Structure
REQ-032 SHALL place CODE_W=3, ONEHOT_W=8 and the DEPTH default in shared package priority_codec_pkg, alongside any encoder-side constants.
REQ-033 SHALL implement the FIFO storage and pointers as sub-module code_fifo (parameter DEPTH, width 4); decode, output register and seen_mask stay in priority_decoder.

Verification
REQ-034 SHALL cover single item: reset, then push code 5 with in_none=0 and out_ready=1 -> out_onehot=8'h20 with out_valid 2 edges after acceptance; seen_mask=8'h20.
REQ-035 SHALL cover backpressure fill: out_ready=0, push codes 0,1,2,3,4 -> first code held on output (8'h01), count=4, in_ready=0; then out_ready=1 -> 8'h01,02,04,08,10 in order.
REQ-036 SHALL cover streaming and wrap: out_ready=1, push codes 7,6,...,0 every cycle for 3 rounds -> one output per cycle, correct order, count never above 1, seen_mask=8'hFF.
REQ-037 SHALL cover none and clear: push in_none=1 with in_code=3 -> out_onehot=8'h00, seen_mask unchanged; clr_seen in the same cycle as a handshake of code 2 -> seen_mask=8'h04.
REQ-038 SHALL cover reset mid-operation: with 3 entries queued and out_valid=1, pulse rst_n low mid-cycle -> outputs zero immediately, count=0, no stale output after release.
